// File: rtl/prog_loader.sv
// prog_loader: boot-time loader that turns a byte stream into instruction
// memory writes and holds the CPU in reset until the image is in place.
//
// Stream: COUNT_HI, COUNT_LO (word count N, big-endian), then 4*N bytes,
// each word MSB first. Words go to consecutive word addresses from 0.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   -> one trailing byte, XOR of every preceding byte (header
//                included), is checked in a CHECK state before DONE.
//   undefined -> the final data write goes straight to DONE.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   byte_valid   stream byte present this cycle
//   byte_data    stream byte
//   byte_ready   loader accepts a byte this cycle (registered)
//   imem_we      one-cycle instruction memory write strobe (registered)
//   imem_addr    word address of the write (registered)
//   imem_wdata   word being written (registered)
//   cpu_rst      CPU reset, high until the load completes
//   load_done    sticky, image loaded
//   load_err     sticky, image rejected
module prog_loader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  // One extra bit so that N == DEPTH == 2^ADDR_W is representable.
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_LOAD = CHECK;
`else
  localparam state_t AFTER_LOAD = DONE;
`endif

  state_t            state, stateNext;
  logic [7:0]        countHi, countHiNext;
  logic [15:0]       wordCount, wordCountNext;
  logic [CNT_W-1:0]  wcnt, wcntNext;
  logic [1:0]        byteCnt, byteCntNext;
  logic [23:0]       asmReg, asmNext;
  logic              readyNext, weNext;
  logic [ADDR_W-1:0] addrNext;
  logic [31:0]       wdataNext;
  logic              accept_c;
  logic [15:0]       hdrCount_c;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chkAcc, chkAccNext;
`endif

  assign accept_c   = byte_valid & byte_ready;
  assign hdrCount_c = {countHi, byte_data};

  // Next-state, datapath and registered-output next values.
  always_comb begin
    stateNext     = state;
    countHiNext   = countHi;
    wordCountNext = wordCount;
    wcntNext      = wcnt;
    byteCntNext   = byteCnt;
    asmNext       = asmReg;
    weNext        = 1'b0;
    addrNext      = imem_addr;
    wdataNext     = imem_wdata;
`ifdef LOADER_CHECKSUM_EN
    chkAccNext    = accept_c ? (chkAcc ^ byte_data) : chkAcc;
`endif

    unique case (state)
      HDR_HI: begin
        if (accept_c) begin
          countHiNext = byte_data;
          stateNext   = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept_c) begin
          wordCountNext = hdrCount_c;
          if (hdrCount_c == 16'd0)
            stateNext = AFTER_LOAD;
          else if (32'(hdrCount_c) > DEPTH)
            stateNext = ERROR;
          else
            stateNext = DATA;
        end
      end
      DATA: begin
        if (accept_c) begin
          asmNext     = {asmReg[15:0], byte_data};
          byteCntNext = byteCnt + 2'd1;
          if (byteCnt == 2'd3) begin
            weNext    = 1'b1;
            addrNext  = wcnt[ADDR_W-1:0];
            wdataNext = {asmReg, byte_data};
            wcntNext  = wcnt + CNT_W'(1);
            // Final write and leaving DATA share the same edge.
            if (32'(wcnt) + 32'd1 == 32'(wordCount))
              stateNext = AFTER_LOAD;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        // chkAcc holds the XOR of every byte before the checksum byte.
        if (accept_c)
          stateNext = (byte_data == chkAcc) ? DONE : ERROR;
      end
`endif
      default: begin
        stateNext = state;
      end
    endcase

    readyNext = (stateNext == HDR_HI) || (stateNext == HDR_LO) ||
                (stateNext == DATA)   || (stateNext == CHECK);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HDR_HI;
      countHi    <= 8'd0;
      wordCount  <= 16'd0;
      wcnt       <= '0;
      byteCnt    <= 2'd0;
      asmReg     <= 24'd0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chkAcc     <= 8'd0;
`endif
    end else begin
      state      <= stateNext;
      countHi    <= countHiNext;
      wordCount  <= wordCountNext;
      wcnt       <= wcntNext;
      byteCnt    <= byteCntNext;
      asmReg     <= asmNext;
      byte_ready <= readyNext;
      imem_we    <= weNext;
      imem_addr  <= addrNext;
      imem_wdata <= wdataNext;
      cpu_rst    <= (stateNext != DONE);
      load_done  <= (stateNext == DONE);
      load_err   <= (stateNext == ERROR);
`ifdef LOADER_CHECKSUM_EN
      chkAcc     <= chkAccNext;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: table of whole-image streams with expected
// writes and final flags, plus hand-written sequences for edge timing,
// header rejection and reset in the middle of a load.
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  int errors = 0;
  int checks = 0;

  prog_loader #(.ADDR_W(16), .DEPTH(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t wq[$];

  // Captures every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) wq.push_back('{a: imem_addr, d: imem_wdata});
  end

  typedef struct packed {
    logic [127:0]      stream;    // right-aligned, first byte most significant
    int                len;
    int                gap;       // idle cycles after each byte
    logic              appendChk; // append correct checksum when enabled
    int                nWr;
    logic [2:0][31:0]  wdata;
    logic              done;
    logic              err;
  } vec_t;

  vec_t vecs[7];
  int   nVec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge; returns after the accepting posedge.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: byte %0h never accepted", b);
    end else begin
      @(negedge clk);
    end
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Drives bytes without waiting for ready (terminal states must ignore them).
  task automatic driveRaw(input int n);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'h5A + 8'(i);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic doReset(input logic chk);
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    if (chk) begin
      check("rst_byte_ready", byte_ready, 0);
      check("rst_imem_we",    imem_we,    0);
      check("rst_imem_addr",  imem_addr,  0);
      check("rst_imem_wdata", imem_wdata, 0);
      check("rst_cpu_rst",    cpu_rst,    1);
      check("rst_load_done",  load_done,  0);
      check("rst_load_err",   load_err,   0);
    end
    rst = 1'b0;
    @(negedge clk);
    if (chk) check("post_rst_byte_ready", byte_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] x;
    int         sh;

    vecs[0] = '{stream: 128'h0002DEADBEEF00000001, len: 10, gap: 0, appendChk: 1'b1, nWr: 2,
                wdata: {32'h0, 32'h00000001, 32'hDEADBEEF}, done: 1'b1, err: 1'b0};
    vecs[1] = '{stream: 128'h0000, len: 2, gap: 0, appendChk: 1'b1, nWr: 0,
                wdata: '0, done: 1'b1, err: 1'b0};
    vecs[2] = '{stream: 128'h0401, len: 2, gap: 0, appendChk: 1'b0, nWr: 0,
                wdata: '0, done: 1'b0, err: 1'b1};
    vecs[3] = '{stream: 128'h0001CAFEBABE, len: 6, gap: 1, appendChk: 1'b1, nWr: 1,
                wdata: {32'h0, 32'h0, 32'hCAFEBABE}, done: 1'b1, err: 1'b0};
    vecs[4] = '{stream: 128'h00030102030405060708090A0B0C, len: 14, gap: 2, appendChk: 1'b1, nWr: 3,
                wdata: {32'h090A0B0C, 32'h05060708, 32'h01020304}, done: 1'b1, err: 1'b0};
    nVec = 5;
`ifdef LOADER_CHECKSUM_EN
    // 00^01^11^22^33^44 = 45
    vecs[5] = '{stream: 128'h00011122334445, len: 7, gap: 0, appendChk: 1'b0, nWr: 1,
                wdata: {32'h0, 32'h0, 32'h11223344}, done: 1'b1, err: 1'b0};
    vecs[6] = '{stream: 128'h000111223344FF, len: 7, gap: 0, appendChk: 1'b0, nWr: 1,
                wdata: {32'h0, 32'h0, 32'h11223344}, done: 1'b0, err: 1'b1};
    nVec = 7;
`endif

    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    doReset(1'b1);

    // Table-driven whole-image vectors.
    for (int v = 0; v < nVec; v++) begin
      doReset(1'b0);
      wq.delete();
      x = 8'h00;
      for (int i = 0; i < vecs[v].len; i++) begin
        sh = 8 * (vecs[v].len - 1 - i);
        b  = vecs[v].stream[sh +: 8];
        x  = x ^ b;
        sendByte(b, vecs[v].gap);
      end
`ifdef LOADER_CHECKSUM_EN
      if (vecs[v].appendChk) sendByte(x, 0);
`endif
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_nwrites", v), 32'(wq.size()), 32'(vecs[v].nWr));
      for (int k = 0; k < vecs[v].nWr && k < wq.size(); k++) begin
        check($sformatf("v%0d_wr%0d_addr", v, k), 32'(wq[k].a), 32'(k));
        check($sformatf("v%0d_wr%0d_data", v, k), wq[k].d, vecs[v].wdata[k]);
      end
      check($sformatf("v%0d_load_done", v), load_done, vecs[v].done);
      check($sformatf("v%0d_load_err", v),  load_err,  vecs[v].err);
      check($sformatf("v%0d_cpu_rst", v),   cpu_rst,   !vecs[v].done);
      check($sformatf("v%0d_byte_ready", v), byte_ready, 0);
      driveRaw(3);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_ignored_bytes", v), 32'(wq.size()), 32'(vecs[v].nWr));
      check($sformatf("v%0d_done_sticky", v), load_done, vecs[v].done);
    end

    // Final write, cpu_rst release and load_done all land on one edge.
    doReset(1'b0);
    wq.delete();
    sendByte(8'h00, 0);
    sendByte(8'h01, 0);
    sendByte(8'h12, 0);
    sendByte(8'h34, 0);
    sendByte(8'h56, 0);
    check("edge_pre_we",      imem_we, 0);
    check("edge_pre_cpu_rst", cpu_rst, 1);
    sendByte(8'h78, 0);
    check("edge_we",    imem_we,    1);
    check("edge_addr",  imem_addr,  0);
    check("edge_wdata", imem_wdata, 32'h12345678);
`ifdef LOADER_CHECKSUM_EN
    check("edge_cpu_rst_chk", cpu_rst,   1);
    check("edge_done_chk",    load_done, 0);
    @(negedge clk);
    check("edge_we_one_cycle", imem_we, 0);
    sendByte(8'h00 ^ 8'h01 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78, 0);
    check("edge_chk_cpu_rst", cpu_rst,   0);
    check("edge_chk_done",    load_done, 1);
`else
    check("edge_cpu_rst", cpu_rst,   0);
    check("edge_done",    load_done, 1);
    @(negedge clk);
    check("edge_we_one_cycle", imem_we, 0);
`endif

    // N = DEPTH+1 is rejected on the COUNT_LO edge with no writes.
    doReset(1'b0);
    wq.delete();
    sendByte(8'h04, 0);
    sendByte(8'h01, 0);
    check("err_load_err",   load_err,   1);
    check("err_byte_ready", byte_ready, 0);
    check("err_cpu_rst",    cpu_rst,    1);
    driveRaw(8);
    repeat (2) @(negedge clk);
    check("err_no_writes", 32'(wq.size()), 0);
    check("err_sticky",    load_err,       1);

    // Reset mid-word: partial word is dropped, new image lands at address 0.
    doReset(1'b0);
    wq.delete();
    sendByte(8'h00, 0);
    sendByte(8'h01, 0);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    repeat (2) @(negedge clk);
    check("midrst_no_partial", 32'(wq.size()), 0);
    doReset(1'b0);
    check("midrst_cpu_rst", cpu_rst, 1);
    sendByte(8'h00, 0);
    sendByte(8'h01, 1);
    sendByte(8'h01, 1);
    sendByte(8'h02, 1);
    sendByte(8'h03, 1);
    sendByte(8'h04, 1);
`ifdef LOADER_CHECKSUM_EN
    sendByte(8'h00 ^ 8'h01 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04, 0);
`endif
    repeat (3) @(negedge clk);
    check("midrst_nwrites", 32'(wq.size()), 1);
    if (wq.size() > 0) begin
      check("midrst_addr", 32'(wq[0].a), 0);
      check("midrst_data", wq[0].d, 32'h01020304);
    end
    check("midrst_done", load_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
